serial_subtractor: RTL

Bit-serial two's-complement subtractor with valid/ready handshakes on both sides. It computes one difference bit per clock using a single full-subtractor cell and a registered borrow, the sequential counterpart of the ripple-carry adder datapath. It sits in the arithmetic block beside the adders. It serves area-constrained paths that can tolerate WIDTH-cycle latency in exchange for one bit-cell of logic.

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, registered borrow,
// LSB-first over WIDTH cycles, valid/ready on both sides.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             x, y, d_bit, brw_next;
   logic [WIDTH-1:0] res_ext;

   always_comb begin
      x        = a_q[0];
      y        = b_q[0];
      d_bit    = x ^ y ^ brw_q;
      brw_next = (~x & y) | (~(x ^ y) & brw_q);
      // New bit enters at the MSB; on the last bit this is the complete difference.
      res_ext  = {d_bit, res_q};

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            brw_d = brw_next;
            res_d = res_ext[WIDTH-1:1];
            if (cnt_q == CntLast) begin
               diff_d  = res_ext;
               bout_d  = brw_next;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule
